// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector (zero input encodes to 0).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping to bit 0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] src;

  // Keep requests at or above ptr; fall back to the full vector when none remain.
  always_comb begin
    mask     = ~((N_REQ'(1) << ptr) - N_REQ'(1));
    masked   = req & mask;
    src      = (masked != '0) ? masked : req;
    pick     = src & (~src + N_REQ'(1));
    pick_idx = onehot_to_idx(pick);
    any      = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered grant, one-cycle gap and hold timeout.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit          HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any;
  logic             rel_other;
  logic             hold_hit;

  rr_pick u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // State and output registers; reset drops any grant and re-homes the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: grant from IDLE, release from GRANT; timeout only when the hold limit acts alone.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    rel_other = done | ~req[idx_q] | ~en;
    hold_hit  = HOLD_EN && (hold_q == HOLD_LAST);

    unique case (state_q)
      IDLE: begin
        if (en && any) begin
          gnt_d   = pick;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_other || hold_hit) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          state_d   = IDLE;
          timeout_d = hold_hit && !rel_other;
        end else if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 with directed vectors (MAX_HOLD = 4).
module tb_rr_arbiter_8;
  import arb_pkg::*;

  typedef struct { int idx; int gap; } grant_t;
  typedef struct { bit to; int len; } release_t;

  logic             clk = 1'b0;
  logic             rst, en, done;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid, timeout;

  grant_t   gq[$];
  release_t rq[$];
  int       n_total = 0;
  int       n_pass  = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  function automatic void check(string name, bit ok, int act, int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int enc(logic [N_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor: invariants every cycle, scoreboard pops on grant start and on release.
  bit prev_valid = 1'b0;
  int run_len = 0;
  int idle_len = 0;
  always @(negedge clk) begin
    grant_t   g;
    release_t r;
    check("onehot", (gnt & (gnt - N_REQ'(1))) == '0, int'(gnt), 0);
    check("valid_eq_or", gnt_valid == (|gnt), int'(gnt_valid), int'(|gnt));
    if (gnt_valid) check("idx_encode", int'(gnt_idx) == enc(gnt), int'(gnt_idx), enc(gnt));
    if (!(prev_valid && !gnt_valid)) check("timeout_quiet", timeout == 1'b0, int'(timeout), 0);
    if (gnt_valid && !prev_valid) begin
      if (gq.size() == 0) begin
        check("unexpected_grant", 1'b0, int'(gnt_idx), -1);
      end else begin
        g = gq.pop_front();
        check("grant_idx", int'(gnt_idx) == g.idx, int'(gnt_idx), g.idx);
        check("grant_vec", gnt == (N_REQ'(1) << g.idx), int'(gnt), 1 << g.idx);
        if (g.gap >= 0) check("grant_gap", idle_len == g.gap, idle_len, g.gap);
      end
      run_len = 1;
    end else if (gnt_valid) begin
      run_len++;
    end
    if (!gnt_valid && prev_valid) begin
      if (rq.size() == 0) begin
        check("unexpected_release", 1'b0, run_len, -1);
      end else begin
        r = rq.pop_front();
        check("release_timeout", timeout == r.to, int'(timeout), int'(r.to));
        check("grant_len", run_len == r.len, run_len, r.len);
      end
      idle_len = 1;
    end else if (!gnt_valid) begin
      idle_len++;
    end
    prev_valid = gnt_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(int idx, int gap);
    grant_t g;
    g.idx = idx;
    g.gap = gap;
    gq.push_back(g);
  endtask

  task automatic push_r(bit to, int len);
    release_t r;
    r.to  = to;
    r.len = len;
    rq.push_back(r);
  endtask

  task automatic wait_grant();
    for (int k = 0; k < 40; k++) begin
      if (gnt_valid) return;
      tick();
    end
    check("grant_wait_expired", 1'b0, 0, 1);
  endtask

  task automatic wait_release();
    for (int k = 0; k < 40; k++) begin
      if (!gnt_valid) return;
      tick();
    end
    check("release_wait_expired", 1'b0, 1, 0);
  endtask

  // Rotation, then wrap/skip: request vector applied at each release and the next expected index.
  logic [N_REQ-1:0] rel_req [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                     8'hFF, 8'hFF, 8'h20, 8'h05, 8'h05, 8'h00};
  int               nxt_idx [12] = '{1, 2, 3, 4, 5, 6, 7, 0, 5, 0, 2, -1};

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    repeat (3) tick();
    check("rst_gnt", gnt == '0, int'(gnt), 0);
    check("rst_idx", gnt_idx == '0, int'(gnt_idx), 0);
    check("rst_valid", gnt_valid == 1'b0, int'(gnt_valid), 0);
    check("rst_timeout", timeout == 1'b0, int'(timeout), 0);

    push_g(0, -1);
    rst = 1'b0;
    tick();
    check("first_grant_latency", gnt == 8'h01, int'(gnt), 1);

    for (int s = 0; s < 12; s++) begin
      wait_grant();
      push_r(1'b0, 1);
      if (nxt_idx[s] >= 0) push_g(nxt_idx[s], 1);
      done = 1'b1;
      req  = rel_req[s];
      tick();
      done = 1'b0;
    end

    // Hold limit alone: timeout pulse, then immediate re-grant after the gap.
    req = 8'h10;
    push_g(4, -1);
    push_r(1'b1, 4);
    push_g(4, 1);
    wait_grant();
    wait_release();
    wait_grant();
    // done coinciding with the hold limit suppresses timeout.
    push_r(1'b0, 4);
    repeat (3) tick();
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;

    // Request drop releases without timeout.
    req = 8'h08;
    push_g(3, -1);
    push_r(1'b0, 2);
    wait_grant();
    tick();
    req = 8'h00;
    tick();

    // Enable low releases and blocks new grants.
    req = 8'h40;
    push_g(6, -1);
    push_r(1'b0, 1);
    wait_grant();
    en = 1'b0;
    repeat (5) tick();
    check("en_low_no_grant", gnt_valid == 1'b0, int'(gnt_valid), 0);
    push_g(6, -1);
    en = 1'b1;
    wait_grant();

    // Reset mid-grant drops the grant and re-homes the pointer to 0.
    push_r(1'b0, 2);
    tick();
    rst = 1'b1;
    req = 8'h81;
    tick();
    check("midrst_gnt", gnt == '0, int'(gnt), 0);
    check("midrst_idx", gnt_idx == '0, int'(gnt_idx), 0);
    rst = 1'b0;
    push_g(0, -1);
    push_r(1'b0, 1);
    wait_grant();
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    repeat (3) tick();

    check("grant_queue_drained", gq.size() == 0, gq.size(), 0);
    check("release_queue_drained", rq.size() == 0, rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
